// File: rtl/reg_file_32x32.sv
// 2**ADDR_W x DATA_W register file, two read ports and one write port; register 0 reads as zero.
// Reads are combinational with write-first bypass; a write lands on the next rising clk.
// Never stalls: every write with a nonzero address commits and bumps wr_cnt.
module reg_file_32x32 #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic [15:0]       wr_cnt
);

    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NREG];
    logic [NREG-1:0]   wsel;
    logic              wr_commit;

    assign wr_commit = we && (waddr != '0);

    always_comb begin
        wsel = '0;
        if (wr_commit) begin
            wsel[waddr] = 1'b1;
        end
    end

    // Entry 0 has no storage; it is tied to zero so reads of r0 need no special case.
    for (genvar i = 0; i < NREG; i++) begin : g_reg
        if (i == 0) begin : g_zero
            assign regs[i] = '0;
        end else begin : g_flop
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    regs[i] <= '0;
                end else if (wsel[i]) begin
                    regs[i] <= wdata;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt <= '0;
        end else if (wr_commit) begin
            wr_cnt <= wr_cnt + 16'd1;
        end
    end

    // Bypass is gated by wr_commit, so raddr=0 still returns zero; reset overrides everything.
    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        if (rst_n) begin
            rdata1 = (wr_commit && (raddr1 == waddr)) ? wdata : regs[raddr1];
            rdata2 = (wr_commit && (raddr2 == waddr)) ? wdata : regs[raddr2];
        end
    end

endmodule

// File: tb/tb_reg_file_32x32.sv
// Directed bench for reg_file_32x32 with a reference model and an expected-value queue.
module tb_reg_file_32x32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic [15:0] wr_cnt;

    always #5 clk = ~clk;

    reg_file_32x32 #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .raddr1 (raddr1),
        .rdata1 (rdata1),
        .raddr2 (raddr2),
        .rdata2 (rdata2),
        .wr_cnt (wr_cnt)
    );

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] model [32];
    logic [15:0] mcnt;
    int          compared   = 0;
    int          mismatched = 0;

    task automatic push(input string tag, input logic [31:0] e);
        exp_t x;
        x.tag = tag;
        x.exp = e;
        sb.push_back(x);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        exp_t x;
        if (sb.size() == 0) begin
            mismatched++;
            $error("FAIL sb_empty: observed %h with no expected value queued", obs);
        end else begin
            x = sb.pop_front();
            compared++;
            assert (obs === x.exp) else begin
                mismatched++;
                $error("FAIL %s: observed %h expected %h", x.tag, obs, x.exp);
            end
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) model[i] = '0;
        mcnt = '0;
    endtask

    // Write on the next rising edge; the model only takes committed writes.
    task automatic drive_wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        we    = 1'b1;
        waddr = a;
        wdata = d;
        @(posedge clk);
        if (rst_n && a != 5'd0) begin
            model[a] = d;
            mcnt     = mcnt + 16'd1;
        end
        #1 we = 1'b0;
    endtask

    task automatic rd_chk(input logic [4:0] a1, input logic [4:0] a2, input string tag);
        @(negedge clk);
        raddr1 = a1;
        raddr2 = a2;
        push({tag, "_p1"}, model[a1]);
        push({tag, "_p2"}, model[a2]);
        #2;
        pop_chk(rdata1);
        pop_chk(rdata2);
    endtask

    task automatic cnt_chk(input string tag);
        push(tag, {16'h0, mcnt});
        #1;
        pop_chk({16'h0, wr_cnt});
    endtask

    initial begin
        rst_n  = 1'b0;
        we     = 1'b0;
        waddr  = '0;
        wdata  = '0;
        raddr1 = 5'd5;
        raddr2 = 5'd9;
        model_clear();

        // Reset state, and a bypass-eligible write held off by reset
        #2;
        push("rst_rdata1", 32'h0); pop_chk(rdata1);
        push("rst_rdata2", 32'h0); pop_chk(rdata2);
        push("rst_wr_cnt", 32'h0); pop_chk({16'h0, wr_cnt});
        @(negedge clk);
        we = 1'b1; waddr = 5'd5; wdata = 32'hCAFE_F00D; raddr1 = 5'd5;
        #2;
        push("rst_no_bypass", 32'h0); pop_chk(rdata1);
        @(posedge clk);
        #1 we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rd_chk(5'd5, 5'd0, "rst_write_discarded");
        cnt_chk("rst_write_cnt");

        // Basic write then read next cycle
        drive_wr(5'd5, 32'hDEAD_BEEF);
        rd_chk(5'd5, 5'd5, "r5_both_ports");
        push("r5_wr_cnt", 32'd1); #1; pop_chk({16'h0, wr_cnt});

        // Writes to r0 are dropped and do not count
        drive_wr(5'd0, 32'hFFFF_FFFF);
        rd_chk(5'd0, 5'd0, "r0_write");
        push("r0_wr_cnt", 32'd1); #1; pop_chk({16'h0, wr_cnt});

        // Per-port bypass: port 1 hits the write, port 2 sees the old r8
        drive_wr(5'd8, 32'h8888_0008);
        @(negedge clk);
        we = 1'b1; waddr = 5'd7; wdata = 32'h1234_5678;
        raddr1 = 5'd7; raddr2 = 5'd8;
        push("bypass_p1", 32'h1234_5678);
        push("bypass_p2", 32'h8888_0008);
        #2;
        pop_chk(rdata1);
        pop_chk(rdata2);
        @(posedge clk);
        model[7] = 32'h1234_5678;
        mcnt     = mcnt + 16'd1;
        #1 we = 1'b0;
        rd_chk(5'd7, 5'd8, "after_bypass");

        // we=0 ignores address and data
        @(negedge clk);
        waddr = 5'd9; wdata = 32'h0BAD_0BAD;
        @(posedge clk);
        rd_chk(5'd9, 5'd7, "we0_hold");
        cnt_chk("we0_cnt");

        // Asynchronous reset in mid-cycle wipes state without a clk edge
        drive_wr(5'd3, 32'hA5A5_A5A5);
        rd_chk(5'd3, 5'd5, "r3_before_rst");
        #1 rst_n = 1'b0;
        model_clear();
        #1;
        push("async_rst_r3", 32'h0); pop_chk(rdata1);
        push("async_rst_cnt", 32'h0); pop_chk({16'h0, wr_cnt});
        @(negedge clk);
        rst_n = 1'b1;
        rd_chk(5'd3, 5'd7, "after_rst_lost");

        // Fill every register with its index, then read pairs
        for (int i = 1; i < 32; i++) drive_wr(5'(i), 32'(i));
        push("fill_wr_cnt", 32'd31); #1; pop_chk({16'h0, wr_cnt});
        for (int i = 0; i < 32; i++) rd_chk(5'(i), 5'(31 - i), "fill_pair");
        rd_chk(5'd17, 5'd17, "same_reg");

        // Run wr_cnt through its wrap
        for (int i = 0; i < 65504; i++) drive_wr(5'((i % 31) + 1), 32'(i) ^ 32'hC0DE_0000);
        push("cnt_ffff", 32'h0000_FFFF); #1; pop_chk({16'h0, wr_cnt});
        drive_wr(5'd12, 32'h600D_CAFE);
        push("cnt_wrap", 32'h0); #1; pop_chk({16'h0, wr_cnt});
        rd_chk(5'd12, 5'd1, "wrap_regs_a");
        rd_chk(5'd30, 5'd31, "wrap_regs_b");

        if (sb.size() != 0) begin
            mismatched++;
            $error("FAIL sb_leftover: observed %0d queued expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
